// File: rtl/io_access_ctrl_if.sv
// Device-side bus of the I/O access sequencer: one-hot select, registered
// address/data, level read/write strobes, and the device's data/acknowledge.
interface io_access_ctrl_if;
  logic [3:0]  dev_sel;
  logic [3:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_re;
  logic        dev_we;
  logic [31:0] dev_rdata;
  logic        dev_ack;

  modport master (
    output dev_sel, dev_addr, dev_wdata, dev_re, dev_we,
    input  dev_rdata, dev_ack
  );

  modport slave (
    input  dev_sel, dev_addr, dev_wdata, dev_re, dev_we,
    output dev_rdata, dev_ack
  );
endinterface

// File: rtl/io_access_ctrl.sv
// Sequences CPU I/O reads/writes onto one of four peripherals with a
// request/acknowledge handshake, stalling the CPU until completion or error.
module io_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [5:0]  BASE0   = 6'h06,
  parameter logic [5:0]  BASE1   = 6'h07,
  parameter logic [5:0]  BASE2   = 6'h08,
  parameter logic [5:0]  BASE3   = 6'h09
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  output logic        cpu_stall,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic [1:0]  dbg_state,
  io_access_ctrl_if.master dev
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        err_hit;
  logic        op_read;
  logic [3:0]  sel_q;
  logic [3:0]  addr_q;
  logic [31:0] wdata_q;
  logic        re_q;
  logic        we_q;

  logic        req;
  logic        valid;
  logic [3:0]  dec_sel;

  // Lowest device index wins if BASE parameters overlap.
  always_comb begin
    dec_sel = 4'b0000;
    if (addr[9:4] == BASE0)      dec_sel = 4'b0001;
    else if (addr[9:4] == BASE1) dec_sel = 4'b0010;
    else if (addr[9:4] == BASE2) dec_sel = 4'b0100;
    else if (addr[9:4] == BASE3) dec_sel = 4'b1000;
  end

  assign req   = io_read | io_write;
  assign valid = (dec_sel != 4'b0000) & (io_read ^ io_write);

  // Handshake: strobe (dev_re/dev_we) and dev_sel stay high for every ACCESS
  // cycle; the transfer completes on the first rising edge that sees dev_ack,
  // and dev_ack outside ACCESS has no effect.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      err_hit <= 1'b0;
      op_read <= 1'b0;
      rdata   <= 32'd0;
      bus_err <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= 4'h0;
      wdata_q <= 32'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr[3:0];
            wdata_q <= wdata;
            op_read <= io_read;
            cnt     <= 8'd0;
            rdata   <= 32'd0;
            if (valid) begin
              sel_q   <= dec_sel;
              re_q    <= io_read;
              we_q    <= io_write;
              err_hit <= 1'b0;
              state   <= ACCESS;
            end else begin
              sel_q   <= 4'b0000;
              re_q    <= 1'b0;
              we_q    <= 1'b0;
              err_hit <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ACCESS: begin
          if (dev.dev_ack) begin
            if (op_read) rdata <= dev.dev_rdata;
            sel_q <= 4'b0000;
            re_q  <= 1'b0;
            we_q  <= 1'b0;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdata   <= 32'd0;
            err_hit <= 1'b1;
            sel_q   <= 4'b0000;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          sel_q <= 4'b0000;
          re_q  <= 1'b0;
          we_q  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Setting on the DONE exit takes priority over a same-cycle clear.
      if (state == DONE && err_hit) bus_err <= 1'b1;
      else if (err_clr)             bus_err <= 1'b0;
    end
  end

  assign cpu_stall = rst_n & (((state == IDLE) & req) | (state == ACCESS));
  assign dbg_state = state;

  assign dev.dev_sel   = sel_q;
  assign dev.dev_addr  = addr_q;
  assign dev.dev_wdata = wdata_q;
  assign dev.dev_re    = re_q;
  assign dev.dev_we    = we_q;

endmodule

// File: tb/tb_io_access_ctrl.sv
// Bench for io_access_ctrl: table of accesses plus random ones, a scoreboard
// queue of expected {err, rdata}, and hand-written reset/ignore sequences.
module tb_io_access_ctrl;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [9:0]  addr = 10'd0;
  logic [31:0] wdata = 32'd0;
  logic        err_clr = 1'b0;
  logic        cpu_stall;
  logic [31:0] rdata;
  logic        bus_err;
  logic [1:0]  dbg_state;

  io_access_ctrl_if dev();

  io_access_ctrl #(.TIMEOUT(TO)) u_dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .io_read   (io_read),
    .io_write  (io_write),
    .addr      (addr),
    .wdata     (wdata),
    .err_clr   (err_clr),
    .cpu_stall (cpu_stall),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .dbg_state (dbg_state),
    .dev       (dev.master)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          ack_cyc;
    logic [31:0] dev_rdata;
    logic [3:0]  exp_sel;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [9:0] a,
                              input logic [31:0] wd, input int ack, input logic [31:0] drd,
                              input logic [3:0] sel, input int acc, input logic err,
                              input logic [31:0] rd_exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.ack_cyc = ack;
    v.dev_rdata = drd; v.exp_sel = sel; v.exp_acc = acc; v.exp_err = err;
    v.exp_rdata = rd_exp;
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [9:0] a);
    case (a[9:4])
      6'h06:   return 4'b0001;
      6'h07:   return 4'b0010;
      6'h08:   return 4'b0100;
      6'h09:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int op;
    logic ok;
    logic acked;
    op = $urandom_range(0, 2);
    v.rd = (op != 1);
    v.wr = (op != 0);
    v.addr = {6'($urandom_range(4, 11)), 4'($urandom_range(0, 15))};
    v.wdata = $urandom;
    v.ack_cyc = $urandom_range(0, 6);
    v.dev_rdata = $urandom;
    ok = (ref_sel(v.addr) != 4'b0000) && (op != 2);
    acked = (v.ack_cyc >= 1) && (v.ack_cyc <= TO);
    v.exp_sel = ok ? ref_sel(v.addr) : 4'b0000;
    v.exp_acc = !ok ? 0 : (acked ? v.ack_cyc : TO);
    v.exp_err = !(ok && acked);
    v.exp_rdata = (ok && acked && v.rd) ? v.dev_rdata : 32'd0;
    return v;
  endfunction

  // driver: one complete access from request cycle to the IDLE cycle after DONE
  task automatic run_vec(input vec_t v, input bit clr_in_done, input bit keep_err);
    int cyc;
    bit done;
    logic [32:0] e;
    e = '0;
    @(negedge clock);
    io_read = v.rd; io_write = v.wr; addr = v.addr; wdata = v.wdata;
    dev.dev_rdata = v.dev_rdata; dev.dev_ack = 1'b0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    #1 check("stall_req", cpu_stall, 1);
    done = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      dev.dev_ack = 1'b0;
      if (cpu_stall) begin
        check("dev_sel", dev.dev_sel, v.exp_sel);
        check("strobe", {dev.dev_re, dev.dev_we}, {v.rd, v.wr});
        check("dev_addr", dev.dev_addr, v.addr[3:0]);
        check("dev_wdata", dev.dev_wdata, v.wdata);
        if (cyc == v.ack_cyc) dev.dev_ack = 1'b1;
      end else begin
        done = 1;
        e = exp_q.pop_front();
        check("done_cycle", cyc, v.exp_acc + 1);
        check("rdata", rdata, e[31:0]);
        check("done_idle_bus", {dev.dev_sel, dev.dev_re, dev.dev_we}, 0);
        dev.dev_ack = 1'b1;
        err_clr = clr_in_done;
      end
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL access_bound: no DONE within %0d cycles at addr %0h", cyc, v.addr);
      exp_q.delete();
      io_read = 1'b0; io_write = 1'b0; dev.dev_ack = 1'b0;
      return;
    end
    @(negedge clock);
    dev.dev_ack = 1'b0; err_clr = 1'b0; io_read = 1'b0; io_write = 1'b0;
    #1;
    check("bus_err", bus_err, e[32]);
    check("stall_idle", cpu_stall, 0);
    check("rdata_hold", rdata, e[31:0]);
    if (e[32] && !keep_err) begin
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      #1 check("err_clr", bus_err, 0);
    end
  endtask

  initial begin
    dev.dev_ack = 1'b0;
    dev.dev_rdata = 32'd0;

    vecs.push_back(mk(1, 0, 10'h070, 32'h0,    1, 32'h0000_00A5, 4'b0010, 1, 0, 32'h0000_00A5));
    vecs.push_back(mk(0, 1, 10'h064, 32'h1234, 4, 32'hFFFF_FFFF, 4'b0001, 4, 0, 32'h0));
    vecs.push_back(mk(0, 1, 10'h3F0, 32'h55,   1, 32'h77,        4'b0000, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 10'h080, 32'h0,    0, 32'hDEAD_BEEF, 4'b0100, 4, 1, 32'h0));
    vecs.push_back(mk(1, 0, 10'h08C, 32'h0,    4, 32'h1234_5678, 4'b0100, 4, 0, 32'h1234_5678));
    vecs.push_back(mk(1, 1, 10'h080, 32'h9,    1, 32'h1,         4'b0000, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 10'h09F, 32'h0,    2, 32'hCAFE_F00D, 4'b1000, 2, 0, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 1, 10'h095, 32'hA5A5, 3, 32'h1111,      4'b1000, 3, 0, 32'h0));
    vecs.push_back(mk(1, 0, 10'h061, 32'h0,    1, 32'h42,        4'b0001, 1, 0, 32'h42));
    vecs.push_back(mk(1, 0, 10'h0A0, 32'h0,    1, 32'h3,         4'b0000, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 10'h07F, 32'h0,    5, 32'h9,         4'b0010, 4, 1, 32'h0));
    for (int i = 0; i < 10; i++) vecs.push_back(rand_vec());

    // reset values, with a request pending to show the stall is gated
    io_read = 1'b1;
    addr = 10'h070;
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", cpu_stall, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_bus", {dev.dev_sel, dev.dev_addr, dev.dev_re, dev.dev_we}, 0);
    check("rst_wdata", dev.dev_wdata, 0);
    check("rst_state", dbg_state, 0);
    io_read = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0, 1'b0);

    // dev_ack while IDLE must not start or complete anything
    @(negedge clock);
    dev.dev_ack = 1'b1;
    dev.dev_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    #1;
    check("idle_ack_state", dbg_state, 0);
    check("idle_ack_stall", cpu_stall, 0);
    check("idle_ack_rdata", rdata, vecs[vecs.size()-1].exp_rdata);
    dev.dev_ack = 1'b0;

    // error set and err_clr in the same cycle: set wins; flag left set
    run_vec(mk(0, 1, 10'h3F0, 32'h1, 0, 32'h0, 4'b0000, 0, 1, 32'h0), 1'b1, 1'b1);

    // reset in the second ACCESS cycle of a keypad read
    @(negedge clock);
    io_read = 1'b1; addr = 10'h090; dev.dev_ack = 1'b0;
    @(negedge clock);
    #1 check("kp_re", dev.dev_re, 1);
    @(negedge clock);
    #1 check("kp_sel", dev.dev_sel, 4'b1000);
    rst_n = 1'b0;
    #1;
    check("arst_bus", {dev.dev_sel, dev.dev_re, dev.dev_we}, 0);
    check("arst_stall", cpu_stall, 0);
    check("arst_bus_err", bus_err, 0);
    check("arst_rdata", rdata, 0);
    io_read = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1 check("post_rst_state", dbg_state, 0);
    run_vec(mk(1, 0, 10'h070, 32'h0, 2, 32'h0000_005A, 4'b0010, 2, 0, 32'h0000_005A), 1'b0, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/io_access_ctrl.md
# io_access_ctrl

Sequencer between the CPU and the memory-mapped I/O bus. It accepts the controller's `IORead`/`IOWrite` decisions for the region `0xFFFFFC00–0xFFFFFFFF`, decodes the low address bits to one of four peripherals, and runs a request/acknowledge handshake with that device. It stalls the CPU until the access completes, a timeout fires, or a decode error occurs. It sits between the decoder/execute stage and the LED, switch, seven-segment and keypad peripherals.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of ACCESS cycles to wait for `dev_ack`; legal range 1–255.
- `BASE0`, 6'h06: `addr[9:4]` match for device 0 (LEDs).
- `BASE1`, 6'h07: match for device 1 (switches).
- `BASE2`, 6'h08: match for device 2 (seven-segment).
- `BASE3`, 6'h09: match for device 3 (keypad).

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_read` in 1: CPU I/O read request (level, held while stalled).
- `io_write` in 1: CPU I/O write request (level, held while stalled).
- `addr` in 10: `ALU_result[9:0]` of the access.
- `wdata` in 32: store data.
- `err_clr` in 1: clears `bus_err` synchronously.
- `cpu_stall` out 1: freezes PC/pipeline while high.
- `rdata` out 32: read data returned to write-back; valid in DONE.
- `bus_err` out 1: sticky error flag.
- `dev_sel` out 4: one-hot device select.
- `dev_addr` out 4: `addr[3:0]`, registered.
- `dev_wdata` out 32: registered store data.
- `dev_re` out 1: read strobe, held during ACCESS.
- `dev_we` out 1: write strobe, held during ACCESS.
- `dev_rdata` in 32: read data from the selected device (muxed externally).
- `dev_ack` in 1: device completion, one or more cycles.

## Operation
- States: IDLE, ACCESS, DONE. 2-bit encoding. Unused encoding → IDLE.
- IDLE:
  - `req = io_read | io_write`.
  - If `req`, latch `addr[3:0]`, `wdata`, the op, and the decoded `dev_sel`. Clear `cnt`.
  - Valid request: one BASE matches and exactly one of read/write is set → ACCESS.
  - Unmapped address, or `io_read & io_write` both high → DONE with `err_hit=1`, `rdata=0`, no device strobe.
- ACCESS:
  - `dev_sel`, `dev_addr`, `dev_wdata` are stable. `dev_re` or `dev_we` is high for the whole state.
  - On `dev_ack`: capture `dev_rdata` into `rdata` (reads only; writes leave `rdata=0`) → DONE.
  - Else if `cnt == TIMEOUT-1`: `rdata=0`, `err_hit=1` → DONE.
  - Else `cnt` increments. `cnt` is 8-bit and never wraps, because the exit at `TIMEOUT-1` precedes overflow.
  - If `dev_ack` and the timeout coincide, `dev_ack` wins and there is no error.
- DONE:
  - Lasts exactly one cycle. All strobes and `dev_sel` are low. `rdata` is held.
  - `io_read`/`io_write` are ignored here (the same instruction is retiring) → IDLE.
- `bus_err`:
  - Set on the clock edge leaving DONE when `err_hit`.
  - Cleared by `err_clr` or reset. If set and clear happen in the same cycle, the set wins.
- Decode: a BASE match requires equality on `addr[9:4]`. If parameters overlap, the lowest device index wins.

## Timing
- `cpu_stall = (state==IDLE & req) | (state==ACCESS)`. It is combinational in IDLE, low in DONE, and forced to 0 while `rst_n` is low.
- Minimum access, with ack in the first ACCESS cycle:
  - cycle 0: IDLE with request, stall=1.
  - cycle 1: ACCESS, ack, stall=1.
  - cycle 2: DONE, stall=0, `rdata` valid.
  - The CPU advances at the end of cycle 2.
- Ack after N ACCESS cycles: DONE arrives at cycle N+1 relative to the request cycle.
- Timeout: DONE arrives at cycle `TIMEOUT+1`.
- Error path (unmapped or both ops): DONE at cycle 1. `bus_err` visible from cycle 2.
- Reset values: state IDLE; `cnt` 0; `rdata` 0; `bus_err` 0; `dev_sel` 0; `dev_addr` 0; `dev_wdata` 0; `dev_re`/`dev_we` 0; `cpu_stall` 0.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronous). No DONE cycle is produced and there is no error flag.
- `dev_ack` in IDLE or DONE is ignored.

## Test plan
- Switch read (`addr=10'h070`, `io_read`), `dev_ack` one cycle after ACCESS entry with `dev_rdata=32'h0000_00A5` → stall high 2 cycles; `dev_sel=4'b0010`, `dev_re=1`; DONE `rdata=32'hA5`; `bus_err=0`.
- LED write (`addr=10'h064`, `wdata=32'h1234`), ack delayed 3 cycles → `dev_we` high 4 cycles with `dev_addr=4'h4` and `dev_wdata=32'h1234`; stall released at cycle 5; `rdata=0`.
- Unmapped write (`addr=10'h3F0`) → no strobe or `dev_sel`; stall high 1 cycle; DONE at cycle 1; `bus_err=1` from cycle 2; `err_clr` pulse → 0.
- Timeout: `TIMEOUT=4`, seg read with no ack → `dev_re` high 4 cycles; DONE `rdata=0`; `bus_err=1`. Repeat with ack on the 4th cycle → no error.
- `io_read=io_write=1` at `addr=10'h080` → error path, no strobe, `bus_err=1`.
- Reset mid-ACCESS (cycle 2 of a pending keypad read) → all outputs 0 asynchronously. After release, state is IDLE; a fresh switch read completes normally with `bus_err=0`.
